// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one APB master between NREQ requesters.
// Each granted command runs a fixed SETUP + XFER_CYCLES ACCESS window, then a one-cycle COMPLETE.
module apb_rr_master_arbiter #(
  parameter int NREQ        = 2,
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 8,
  parameter int XFER_CYCLES = 2
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_rw,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err,
  output logic                     transfer,
  output logic                     READ_WRITE,
  output logic [ADDR_W-1:0]        apb_write_paddr,
  output logic [DATA_W-1:0]        apb_write_data,
  output logic [ADDR_W-1:0]        apb_read_paddr,
  input  logic [DATA_W-1:0]        apb_read_data_out,
  input  logic                     PSLVERR,
  output logic [1:0]               dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(XFER_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, COMPLETE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     ptr_q, win_q, pick;
  logic              rw_q, err_q;
  logic [ADDR_W-1:0] waddr_q, raddr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              grant_now, last_access;

  // First set request bit scanning upward from ptr_q+1, wrapping.
  always_comb begin
    int  j;
    logic found;
    pick  = ptr_q;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j[IW-1:0]]) begin
        found = 1'b1;
        pick  = j[IW-1:0];
      end
    end
  end

  assign grant_now   = (state_q == IDLE) && (|req);
  assign last_access = (state_q == ACCESS) && (cnt_q == CW'(XFER_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:     if (|req) state_d = SETUP;
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (last_access) state_d = COMPLETE;
        else             cnt_d   = cnt_q + 1'b1;
      end
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= IW'(NREQ - 1);
      win_q   <= '0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Command is latched once at grant; only the active direction's bus moves.
      if (grant_now) begin
        win_q <= pick;
        ptr_q <= pick;
        rw_q  <= req_rw[pick];
        if (req_rw[pick]) begin
          raddr_q <= req_addr[pick*ADDR_W +: ADDR_W];
        end else begin
          waddr_q <= req_addr[pick*ADDR_W +: ADDR_W];
          wdata_q <= req_wdata[pick*DATA_W +: DATA_W];
        end
      end
      if (last_access) begin
        err_q <= PSLVERR;
        if (rw_q) rdata_q <= apb_read_data_out;
      end
    end
  end

  always_comb begin
    gnt  = '0;
    done = '0;
    if (state_q != IDLE)     gnt[win_q]  = 1'b1;
    if (state_q == COMPLETE) done[win_q] = 1'b1;
  end

  assign transfer        = (state_q == SETUP) || (state_q == ACCESS);
  assign READ_WRITE      = rw_q;
  assign apb_write_paddr = waddr_q;
  assign apb_write_data  = wdata_q;
  assign apb_read_paddr  = raddr_q;
  assign rdata           = rdata_q;
  assign err             = err_q;
  assign dbg_state       = state_q;

endmodule

// File: doc/apb_rr_master_arbiter.md
Name: apb_rr_master_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single APB_Protocol master between NREQ requesters, e.g. a CPU port and a DMA port.
- Latches the winning request's command.
- Drives the master's transfer, READ_WRITE and address/data inputs for a fixed-length SETUP+ACCESS window.
- Returns read data and PSLVERR to the winner with a one-cycle done pulse.

Parameters:
NREQ, 2, number of requesters (2..8)
ADDR_W, 9, APB address width; MSB selects slave2
DATA_W, 8, APB data width
XFER_CYCLES, 2, cycles the ACCESS phase is held (>=1)

Ports:
PCLK  input  1  clock, rising edge
PRESET  input  1  asynchronous reset, active-high
req  input  NREQ  per-requester transaction request (level)
req_rw  input  NREQ  per-requester direction: 1=read, 0=write
req_addr  input  NREQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NREQ*DATA_W  packed write data
gnt  output  NREQ  one-hot grant, high SETUP through COMPLETE
done  output  NREQ  one-hot one-cycle completion pulse
rdata  output  DATA_W  read data of last completed read
err  output  1  PSLVERR captured for last completed transfer, valid with done
transfer  output  1  to master: transfer enable
READ_WRITE  output  1  to master: 1=read, 0=write
apb_write_paddr  output  ADDR_W  to master write address
apb_write_data  output  DATA_W  to master write data
apb_read_paddr  output  ADDR_W  to master read address
apb_read_data_out  input  DATA_W  from master read data
PSLVERR  input  1  from master slave error

Behaviour:
- Reset (PRESET high, any time, asynchronous):
  - state=IDLE; all outputs 0; round-robin pointer=NREQ-1, so requester 0 has highest priority first.
  - An in-flight transfer is abandoned; no done pulse.
- States:
  - IDLE: transfer=0, gnt=0. On an edge with req!=0, pick the first set bit scanning from pointer+1 with wrap. Latch its rw/addr/wdata, set pointer=winner, go to SETUP.
  - SETUP, 1 cycle: transfer=1, gnt[winner]=1, command outputs driven. Go to ACCESS; counter=0.
  - ACCESS: transfer=1, command held stable. Counter increments each cycle. On the XFER_CYCLES-th cycle:
    - capture PSLVERR into err;
    - if read, capture apb_read_data_out into rdata;
    - go to COMPLETE.
  - COMPLETE, 1 cycle: transfer=0, done[winner]=1, gnt[winner]=1. Go to IDLE.
- Command drive:
  - Write: apb_write_paddr=addr, apb_write_data=wdata, READ_WRITE=0.
  - Read: apb_read_paddr=addr, READ_WRITE=1.
  - The inactive-direction bus holds its previous value.
  - rdata holds its value through writes.
- Latency: req sampled at edge k → SETUP cycle k+1 → ACCESS k+2..k+1+XFER_CYCLES → done high in cycle k+2+XFER_CYCLES. That is done at k+4 for the default.
- Minimum spacing between transactions is XFER_CYCLES+3 cycles, because IDLE is revisited every time.
- Request rules:
  - Command fields are sampled only at grant; later changes are ignored.
  - Dropping req after grant does not cancel the transfer.
  - req dropped before grant means no transfer.
  - Requester should drop req on done, or it re-enters arbitration.
- Fairness: a continuously asserted req is granted within NREQ transactions.
- Simultaneous requests are resolved only by the pointer; no fixed priority after the first grant.
- Address MSB is passed through untouched; slave decoding stays in the master.
- err is not sticky; it is updated on every completion.

Test Plan:
- Reset then req=01, rw=0, addr=9'h003, wdata=8'h06 → transfer high cycles 1-3 (SETUP+2 ACCESS), READ_WRITE=0, apb_write_paddr=003, apb_write_data=06; done=01 at cycle 4; gnt=01 cycles 1-4.
- Both req=11 held continuously, both writes → grants alternate 0,1,0,1; each done spaced 5 cycles apart.
- Requester 1 read addr 9'h105, master returns 8'h05, PSLVERR=0 → rdata=05, err=0 with done=10; apb_write_paddr unchanged from prior write.
- Read to addr 9'h02D with PSLVERR=1 in the last ACCESS cycle → err=1 with done pulse; next clean transfer → err=0.
- Assert PRESET during ACCESS → all outputs 0 immediately (asynchronous), no done; after release with req=11, requester 0 is granted first.
- Change req_addr and req_wdata during ACCESS, and drop req after SETUP → master inputs keep the latched values; transfer still completes with done.
